// File: rtl/maze_pkg.sv
// Shared types and default sizing for the maze path stack.
package maze_pkg;

   localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
   localparam int unsigned DEFAULT_DEPTH      = 256;
   localparam int unsigned MOVE_W             = 2;

   // Encoded solver move
   typedef enum logic [MOVE_W-1:0] {
      MOVE_RIGHT = 2'b00,
      MOVE_DOWN  = 2'b01,
      MOVE_LEFT  = 2'b10,
      MOVE_UP    = 2'b11
   } move_t;

   // Control FSM states
   typedef enum logic [1:0] {
      COLLECT  = 2'b00,
      REPLAY   = 2'b01,
      FINISHED = 2'b10
   } state_t;

endpackage

// File: rtl/path_stack_mem.sv
// DEPTH x move_t register file: one write port, two combinational read ports.
module stack_mem
   import maze_pkg::*;
#(
   parameter int unsigned DEPTH      = DEFAULT_DEPTH,
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  move_t                 wr_data,
   input  logic [ADDR_WIDTH-1:0] top_addr,
   output move_t                 top_data_c,
   input  logic [ADDR_WIDTH-1:0] rep_addr,
   output move_t                 rep_data_c
);

   move_t mem [DEPTH];

   // Storage is intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign top_data_c = mem[top_addr];
   assign rep_data_c = mem[rep_addr];

endmodule

// File: rtl/path_stack.sv
// Move stack for a maze solver: collects moves with backtracking, then replays
// the stored path bottom to top, one move per cycle.
module path_stack
   import maze_pkg::*;
#(
   parameter int unsigned DEPTH      = DEFAULT_DEPTH,
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  push,
   input  logic                  pop,
   input  logic [1:0]            push_move,
   input  logic                  run,
   output logic [1:0]            top_move,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic [1:0]            move,
   output logic                  move_valid,
   output logic                  replay_done,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int unsigned AW  = ADDR_WIDTH;
   localparam int unsigned SPW = ADDR_WIDTH + 1;

   state_t         state_q, state_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic [SPW-1:0] rd_ptr_q, rd_ptr_d;
   move_t          move_q, move_d;
   logic           move_valid_q, move_valid_d;
   logic           replay_done_q, replay_done_d;
   logic           overflow_q, overflow_d;

   logic           wr_en;
   logic [AW-1:0]  wr_addr;
   move_t          wr_data;
   logic [AW-1:0]  top_addr;
   logic [AW-1:0]  rep_addr;
   move_t          top_data_c;
   move_t          rep_data_c;
   logic           is_empty;
   logic           is_full;
   logic [SPW-1:0] rd_next;

   assign is_empty = (sp_q == '0);
   assign is_full  = (sp_q == SPW'(DEPTH));
   assign rd_next  = rd_ptr_q + SPW'(1);
   assign top_addr = AW'(sp_q - SPW'(1));
   // rd_ptr tracks the entry currently on move; the port prefetches the next one
   assign rep_addr = (state_q == REPLAY) ? AW'(rd_next) : '0;

   stack_mem #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk        (clk),
      .wr_en      (wr_en & ~rst),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .top_addr   (top_addr),
      .top_data_c (top_data_c),
      .rep_addr   (rep_addr),
      .rep_data_c (rep_data_c)
   );

   // Next-state, stack update and replay output selection
   always_comb begin
      state_d       = state_q;
      sp_d          = sp_q;
      rd_ptr_d      = rd_ptr_q;
      move_d        = move_q;
      move_valid_d  = 1'b0;
      replay_done_d = replay_done_q;
      overflow_d    = overflow_q;
      wr_en         = 1'b0;
      wr_addr       = AW'(sp_q);
      wr_data       = move_t'(push_move);

      if (start) begin
         state_d       = COLLECT;
         sp_d          = '0;
         rd_ptr_d      = '0;
         replay_done_d = 1'b0;
         overflow_d    = 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (push && pop && !is_empty) begin
                  wr_en   = 1'b1;
                  wr_addr = top_addr;
               end else if (push) begin
                  if (is_full) begin
                     overflow_d = 1'b1;
                  end else begin
                     wr_en = 1'b1;
                     sp_d  = sp_q + SPW'(1);
                  end
               end else if (pop && !is_empty) begin
                  sp_d = sp_q - SPW'(1);
               end

               // Replay length includes any push accepted this same cycle
               if (run) begin
                  rd_ptr_d = '0;
                  if (sp_d == '0) begin
                     state_d       = FINISHED;
                     replay_done_d = 1'b1;
                  end else begin
                     state_d      = REPLAY;
                     move_valid_d = 1'b1;
                     move_d       = (wr_en && (wr_addr == '0)) ? wr_data : rep_data_c;
                  end
               end
            end

            REPLAY: begin
               if (rd_next == sp_q) begin
                  state_d       = FINISHED;
                  replay_done_d = 1'b1;
               end else begin
                  move_valid_d = 1'b1;
                  move_d       = rep_data_c;
                  rd_ptr_d     = rd_next;
               end
            end

            FINISHED: begin
            end

            default: begin
               state_d = COLLECT;
            end
         endcase
      end
   end

   // State and control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= COLLECT;
         sp_q          <= '0;
         rd_ptr_q      <= '0;
         move_q        <= MOVE_RIGHT;
         move_valid_q  <= 1'b0;
         replay_done_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         sp_q          <= sp_d;
         rd_ptr_q      <= rd_ptr_d;
         move_q        <= move_d;
         move_valid_q  <= move_valid_d;
         replay_done_q <= replay_done_d;
         overflow_q    <= overflow_d;
      end
   end

   assign top_move    = is_empty ? 2'b00 : top_data_c;
   assign empty       = is_empty;
   assign full        = is_full;
   assign count       = sp_q;
   assign overflow    = overflow_q;
   assign move        = move_q;
   assign move_valid  = move_valid_q;
   assign replay_done = replay_done_q;

endmodule

// File: tb/tb_path_stack.sv
// Directed bench for path_stack with a move model and replay scoreboard.
module tb_path_stack;

   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          push;
   logic          pop;
   logic [1:0]    push_move;
   logic          run;
   logic [1:0]    top_move;
   logic          empty;
   logic          full;
   logic          overflow;
   logic [1:0]    move;
   logic          move_valid;
   logic          replay_done;
   logic [AW:0]   count;

   int total = 0;
   int bad   = 0;

   logic [1:0] mdl[$];
   logic [1:0] exp_q[$];

   path_stack #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .push        (push),
      .pop         (pop),
      .push_move   (push_move),
      .run         (run),
      .top_move    (top_move),
      .empty       (empty),
      .full        (full),
      .overflow    (overflow),
      .move        (move),
      .move_valid  (move_valid),
      .replay_done (replay_done),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: outputs are checked 1 time unit after the edge; replayed moves are scored
   task automatic step();
      logic [1:0] e;
      @(posedge clk);
      #1;
      if (move_valid === 1'b1) begin
         total++;
         assert (exp_q.size() != 0)
         else begin
            bad++;
            $error("FAIL spurious_move_valid observed=%0h expected=none", move);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("replay_move", 32'(move), 32'(e));
         end
      end
   endtask

   task automatic do_push(input logic [1:0] m);
      push = 1'b1; push_move = m;
      step();
      push = 1'b0;
      if (mdl.size() < DEPTH) mdl.push_back(m);
   endtask

   task automatic do_pop();
      pop = 1'b1;
      step();
      pop = 1'b0;
      if (mdl.size() > 0) void'(mdl.pop_back());
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      mdl.delete();
      exp_q.delete();
   endtask

   // Run and require exactly k consecutive valid cycles, then replay_done
   task automatic run_expect(input int k, input string tag);
      exp_q = mdl;
      run = 1'b1;
      step();
      run = 1'b0;
      for (int i = 0; i < k; i++) begin
         chk({tag, "_valid"}, 32'(move_valid), 32'(1));
         step();
      end
      chk({tag, "_valid_low"}, 32'(move_valid), 32'(0));
      chk({tag, "_done"}, 32'(replay_done), 32'(1));
      chk({tag, "_all_moves"}, 32'(exp_q.size()), 32'(0));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_empty"}, 32'(empty), 32'(1));
      chk({tag, "_full"}, 32'(full), 32'(0));
      chk({tag, "_count"}, 32'(count), 32'(0));
      chk({tag, "_top"}, 32'(top_move), 32'(0));
      chk({tag, "_move"}, 32'(move), 32'(0));
      chk({tag, "_valid"}, 32'(move_valid), 32'(0));
      chk({tag, "_done"}, 32'(replay_done), 32'(0));
      chk({tag, "_ovf"}, 32'(overflow), 32'(0));
   endtask

   initial begin
      logic [1:0] m;
      logic [1:0] last;
      rst = 1'b1; start = 1'b0; push = 1'b0; pop = 1'b0; push_move = 2'b00; run = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk_reset_vals("reset");

      // Basic path replay
      do_push(2'b00);
      chk("top_after_push", 32'(top_move), 32'(0));
      do_push(2'b01);
      do_push(2'b01);
      do_push(2'b10);
      chk("top_4", 32'(top_move), 32'(2));
      chk("count_4", 32'(count), 32'(4));
      run_expect(4, "basic");
      chk("move_hold", 32'(move), 32'(2));
      chk("count_kept", 32'(count), 32'(4));
      // Inputs ignored once finished
      push = 1'b1; pop = 1'b1; run = 1'b1; push_move = 2'b11;
      step();
      step();
      push = 1'b0; pop = 1'b0; run = 1'b0;
      chk("finished_count", 32'(count), 32'(4));
      chk("finished_top", 32'(top_move), 32'(2));
      chk("finished_done", 32'(replay_done), 32'(1));

      // Backtrack with pop and overwrite
      do_start();
      chk("start_done_clr", 32'(replay_done), 32'(0));
      chk("start_empty", 32'(empty), 32'(1));
      do_push(2'b00);
      do_push(2'b01);
      do_push(2'b11);
      do_pop();
      chk("count_after_pop", 32'(count), 32'(2));
      chk("top_after_pop", 32'(top_move), 32'(1));
      push = 1'b1; pop = 1'b1; push_move = 2'b10;
      step();
      push = 1'b0; pop = 1'b0;
      mdl[mdl.size()-1] = 2'b10;
      chk("overwrite_top", 32'(top_move), 32'(2));
      chk("overwrite_count", 32'(count), 32'(2));
      run_expect(2, "backtrack");

      // Empty stack: pop ignored, push+pop acts as push, run goes straight to done
      do_start();
      do_pop();
      chk("pop_empty_count", 32'(count), 32'(0));
      chk("pop_empty_ovf", 32'(overflow), 32'(0));
      run_expect(0, "empty_run");
      do_start();
      push = 1'b1; pop = 1'b1; push_move = 2'b11;
      step();
      push = 1'b0; pop = 1'b0;
      mdl.push_back(2'b11);
      chk("pushpop_empty_count", 32'(count), 32'(1));
      chk("pushpop_empty_top", 32'(top_move), 32'(3));

      // Run together with push: replay includes the new entry
      push = 1'b1; push_move = 2'b10; run = 1'b1;
      mdl.push_back(2'b10);
      exp_q = mdl;
      step();
      push = 1'b0; run = 1'b0;
      chk("runpush_valid1", 32'(move_valid), 32'(1));
      step();
      chk("runpush_valid2", 32'(move_valid), 32'(1));
      step();
      chk("runpush_done", 32'(replay_done), 32'(1));
      chk("runpush_drained", 32'(exp_q.size()), 32'(0));
      chk("runpush_count", 32'(count), 32'(2));

      // Abort replay at its third cycle
      do_start();
      for (int i = 0; i < 6; i++) do_push(2'($urandom_range(0, 3)));
      exp_q = mdl;
      run = 1'b1;
      step();
      run = 1'b0;
      step();
      step();
      chk("abort_valid3", 32'(move_valid), 32'(1));
      start = 1'b1;
      step();
      start = 1'b0;
      mdl.delete();
      exp_q.delete();
      chk("abort_valid_low", 32'(move_valid), 32'(0));
      chk("abort_count", 32'(count), 32'(0));
      chk("abort_empty", 32'(empty), 32'(1));
      do_push(2'b11);
      step();
      chk("abort_push_count", 32'(count), 32'(1));
      chk("abort_push_top", 32'(top_move), 32'(3));

      // Fill to capacity, overflow, full replay
      do_start();
      last = 2'b00;
      for (int i = 0; i < DEPTH; i++) begin
         m = 2'($urandom_range(0, 3));
         last = m;
         do_push(m);
      end
      chk("fill_full", 32'(full), 32'(1));
      chk("fill_ovf_clear", 32'(overflow), 32'(0));
      do_push(~last);
      chk("ovf_set", 32'(overflow), 32'(1));
      chk("ovf_full", 32'(full), 32'(1));
      chk("ovf_count", 32'(count), 32'(DEPTH));
      chk("ovf_top", 32'(top_move), 32'(last));
      run_expect(DEPTH, "full_replay");
      chk("full_move_hold", 32'(move), 32'(last));

      // Reset beats start and push
      rst = 1'b1; start = 1'b1; push = 1'b1; push_move = 2'b01;
      step();
      rst = 1'b0; start = 1'b0; push = 1'b0;
      chk_reset_vals("rst_prio");
      step();
      chk("rst_prio_hold_count", 32'(count), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
